// File: rtl/ee357_alu.sv
// Single-cycle registered 32-bit MIPS-style ALU (ADD/SUB/logic/SLT/shifts/JR).
// Optional barrel shifter enabled by defining EE357_ALU_SHIFT_EN.
module ee357_alu (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] opa,
  input  logic [31:0] opb,
  input  logic [5:0]  func,
  output logic [31:0] res,
  output logic        uov,
  output logic        sov,
  output logic        zero,
  output logic        cout
);

  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_XOR = 6'b100110;
  localparam logic [5:0] F_NOR = 6'b100111;
  localparam logic [5:0] F_SLT = 6'b101010;
  localparam logic [5:0] F_JR  = 6'b001000;
`ifdef EE357_ALU_SHIFT_EN
  localparam logic [5:0] F_SLL = 6'b000000;
  localparam logic [5:0] F_SRL = 6'b000010;
  localparam logic [5:0] F_SRA = 6'b000011;
`endif

  logic        is_sub;
  logic [31:0] b_add;
  logic [32:0] sum;
  logic        ovf;

  logic [31:0] res_d, res_q;
  logic        uov_d, uov_q;
  logic        sov_d, sov_q;
  logic        cout_d, cout_q;
  logic        zero_q;

  // One shared adder: SUB and SLT feed ~opb with a carry-in of 1.
  always_comb begin
    is_sub = (func == F_SUB) || (func == F_SLT);
    b_add  = is_sub ? ~opb : opb;
    sum    = {1'b0, opa} + {1'b0, b_add} + {32'd0, is_sub};
    ovf    = (opa[31] == b_add[31]) && (sum[31] != opa[31]);
  end

  always_comb begin
    res_d  = 32'd0;
    uov_d  = 1'b0;
    sov_d  = 1'b0;
    cout_d = 1'b0;
    case (func)
      F_ADD: begin
        res_d  = sum[31:0];
        cout_d = sum[32];
        uov_d  = sum[32];
        sov_d  = ovf;
      end
      F_SUB: begin
        res_d  = sum[31:0];
        cout_d = sum[32];
        uov_d  = ~sum[32];
        sov_d  = ovf;
      end
      F_SLT: begin
        res_d  = {31'd0, sum[31] ^ ovf};
        cout_d = sum[32];
        uov_d  = ~sum[32];
        sov_d  = ovf;
      end
      F_AND: res_d = opa & opb;
      F_OR:  res_d = opa | opb;
      F_XOR: res_d = opa ^ opb;
      F_NOR: res_d = ~(opa | opb);
      F_JR:  res_d = opa;
`ifdef EE357_ALU_SHIFT_EN
      F_SLL: res_d = opb << opa[4:0];
      F_SRL: res_d = opb >> opa[4:0];
      F_SRA: res_d = $unsigned($signed(opb) >>> opa[4:0]);
`endif
      default: res_d = 32'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      res_q  <= 32'd0;
      uov_q  <= 1'b0;
      sov_q  <= 1'b0;
      cout_q <= 1'b0;
      zero_q <= 1'b1;
    end else begin
      res_q  <= res_d;
      uov_q  <= uov_d;
      sov_q  <= sov_d;
      cout_q <= cout_d;
      zero_q <= (res_d == 32'd0);
    end
  end

  assign res  = res_q;
  assign uov  = uov_q;
  assign sov  = sov_q;
  assign zero = zero_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_ee357_alu.sv
// Self-checking bench for ee357_alu: directed corner cases plus random ops
// against an arithmetic reference model.
module tb_ee357_alu;

  logic        clk;
  logic        rst;
  logic [31:0] opa, opb;
  logic [5:0]  func;
  logic [31:0] res;
  logic        uov, sov, zero, cout;

  int checks = 0;
  int errors = 0;

  ee357_alu dut (
    .clk(clk), .rst(rst), .opa(opa), .opb(opb), .func(func),
    .res(res), .uov(uov), .sov(sov), .zero(zero), .cout(cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Returns {res, uov, sov, zero, cout} computed from integer arithmetic.
  function automatic logic [35:0] model(input logic [5:0] f, input logic [31:0] a,
                                        input logic [31:0] b);
    longint sa, sb, s;
    logic [31:0] r;
    logic u, v, c;
    sa = $signed(a);
    sb = $signed(b);
    s  = 0;
    r  = 32'd0;
    u  = 1'b0;
    v  = 1'b0;
    c  = 1'b0;
    case (f)
      6'b100000: begin
        s = sa + sb;
        r = a + b;
        c = (64'(a) + 64'(b)) >= 64'h1_0000_0000;
        u = c;
        v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      6'b100010, 6'b101010: begin
        s = sa - sb;
        r = (f == 6'b101010) ? ((sa < sb) ? 32'd1 : 32'd0) : a - b;
        c = (a >= b);
        u = (a < b);
        v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      6'b100100: r = a & b;
      6'b100101: r = a | b;
      6'b100110: r = a ^ b;
      6'b100111: r = ~(a | b);
      6'b001000: r = a;
`ifdef EE357_ALU_SHIFT_EN
      6'b000000: r = b << a[4:0];
      6'b000010: r = b >> a[4:0];
      6'b000011: r = $unsigned($signed(b) >>> a[4:0]);
`endif
      default: r = 32'd0;
    endcase
    return {r, u, v, (r == 32'd0), c};
  endfunction

  task automatic check(input string tag, input logic [35:0] exp);
    logic [35:0] got;
    got = {res, uov, sov, zero, cout};
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got res=%h flags=%b expected res=%h flags=%b",
             tag, got[35:4], got[3:0], exp[35:4], exp[3:0]);
    end
  endtask

  // Apply one operation, clock it, sample 1ns after the edge.
  task automatic step(input logic r, input logic [5:0] f, input logic [31:0] a,
                      input logic [31:0] b);
    @(negedge clk);
    rst  = r;
    func = f;
    opa  = a;
    opb  = b;
    @(posedge clk);
    #1;
  endtask

  task automatic op_chk(input string tag, input logic [5:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [35:0] exp);
    step(1'b0, f, a, b);
    check(tag, exp);
    check({tag, "_model"}, model(f, a, b));
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [5:0] codes [12];
    logic [5:0] f;
    logic [31:0] a, b;
    logic r;
    codes = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100110, 6'b100111,
              6'b101010, 6'b000000, 6'b000010, 6'b000011, 6'b001000, 6'b000000};
    rst = 1'b1; func = 6'b100000; opa = 32'hFFFF_FFFF; opb = 32'h1;
    step(1'b1, 6'b100000, 32'hFFFF_FFFF, 32'h1);
    check("reset", {32'h0, 4'b0010});

    op_chk("add_wrap", 6'b100000, 32'hFFFF_FFFF, 32'h1, {32'h0, 4'b1011});
    op_chk("add_sov",  6'b100000, 32'h7FFF_FFFF, 32'h1, {32'h8000_0000, 4'b0100});
    op_chk("sub_sov",  6'b100010, 32'h8000_0000, 32'h1, {32'h7FFF_FFFF, 4'b0101});
    op_chk("sub_brw",  6'b100010, 32'h0, 32'h1, {32'hFFFF_FFFF, 4'b1000});
    op_chk("sub_pos",  6'b100010, 32'hFFFF_FFFF, 32'hFFFF_FFFE, {32'h1, 4'b0001});
    op_chk("and",      6'b100100, 32'hFFFF_FFFF, 32'h0033_CCFF, {32'h0033_CCFF, 4'b0000});
    op_chk("or",       6'b100101, 32'h0, 32'h0033_CCFF, {32'h0033_CCFF, 4'b0000});
    op_chk("xor",      6'b100110, 32'hFFFF_FFFF, 32'h0033_CCFF, {32'hFFCC_3300, 4'b0000});
    op_chk("nor",      6'b100111, 32'h0, 32'h0033_CCFF, {32'hFFCC_3300, 4'b0000});
    op_chk("slt_lt",   6'b101010, 32'h0, 32'h1, {32'h1, 4'b1000});
    op_chk("slt_ge",   6'b101010, 32'hFFFF_FFFF, 32'hFFFF_FFFE, {32'h0, 4'b0011});
    op_chk("jr",       6'b001000, 32'h1234_5678, 32'hDEAD_BEEF, {32'h1234_5678, 4'b0000});
    op_chk("jr_zero",  6'b001000, 32'h0, 32'hDEAD_BEEF, {32'h0, 4'b0010});
    op_chk("bad_func", 6'b111111, 32'hFFFF_FFFF, 32'h1, {32'h0, 4'b0010});
`ifdef EE357_ALU_SHIFT_EN
    op_chk("sll1",  6'b000000, 32'h1,  32'h1,         {32'h2, 4'b0000});
    op_chk("sll28", 6'b000000, 32'h1C, 32'hA,         {32'hA000_0000, 4'b0000});
    op_chk("srl1",  6'b000010, 32'h1,  32'h8000_0000, {32'h4000_0000, 4'b0000});
    op_chk("srl31", 6'b000010, 32'h1F, 32'h8000_0000, {32'h1, 4'b0000});
    op_chk("sra1",  6'b000011, 32'h1,  32'h8000_0000, {32'hC000_0000, 4'b0000});
    op_chk("sra31", 6'b000011, 32'hFFFF_FFFF, 32'h8000_0000, {32'hFFFF_FFFF, 4'b0000});
`else
    op_chk("sll_off", 6'b000000, 32'h1,  32'h1,         {32'h0, 4'b0010});
    op_chk("srl_off", 6'b000010, 32'h1,  32'h8000_0000, {32'h0, 4'b0010});
    op_chk("sra_off", 6'b000011, 32'h1F, 32'h8000_0000, {32'h0, 4'b0010});
`endif

    // Reset mid-stream overrides the pending ADD; next op lands one cycle after.
    op_chk("pre_rst", 6'b100000, 32'h7FFF_FFFF, 32'h1, {32'h8000_0000, 4'b0100});
    step(1'b1, 6'b100000, 32'hFFFF_FFFF, 32'h1);
    check("mid_rst", {32'h0, 4'b0010});
    op_chk("post_rst", 6'b100000, 32'hFFFF_FFFF, 32'h1, {32'h0, 4'b1011});
    // Held inputs reload to the same value every edge.
    step(1'b0, 6'b100000, 32'hFFFF_FFFF, 32'h1);
    check("hold", {32'h0, 4'b1011});

    for (int i = 0; i < 400; i++) begin
      f = ($urandom_range(0, 11) == 11) ? 6'($urandom) : codes[$urandom_range(0, 10)];
      a = pick();
      b = pick();
      r = ($urandom_range(0, 29) == 0);
      step(r, f, a, b);
      check("rand", r ? {32'h0, 4'b0010} : model(f, a, b));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ee357_alu.md
EE357_ALU -- requirements
Module: ee357_alu

Interface
REQ-001 No parameters; datapath width fixed at 32 bits.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 opa  input  32  operand A; shift amount (opa[4:0]) for shift ops.
REQ-005 opb  input  32  operand B; value shifted for shift ops.
REQ-006 func  input  6  operation select (MIPS R-type funct encoding).
REQ-007 res  output  32  registered result.
REQ-008 uov  output  1  registered unsigned overflow/borrow flag.
REQ-009 sov  output  1  registered signed (two's-complement) overflow flag.
REQ-010 zero  output  1  registered flag, 1 when res equals 0.
REQ-011 cout  output  1  registered carry-out of the 32-bit adder.

Function
REQ-012 Encodings: ADD 100000, SUB 100010, AND 100100, OR 100101, XOR 100110, NOR 100111, SLT 101010, SLL 000000, SRL 000010, SRA 000011, JR 001000.
REQ-013 Latency exactly one cycle: outputs at edge N+1 reflect inputs sampled at edge N; no handshake; a new operation is accepted every cycle.
REQ-014 ADD: res = (opa+opb) mod 2^32; cout = bit 32 of the sum; uov = cout; sov = 1 when operand signs match and the result sign differs.
REQ-015 SUB: computed as opa + ~opb + 1; res is the low 32 bits; cout = bit 32; uov = ~cout (borrow); sov = 1 when operand signs differ and the result sign differs from opa.
REQ-016 SLT: res = 32'd1 if opa < opb signed (subtraction sign XOR sov), else 0; uov, sov and cout are those of SUB on the same operands.
REQ-017 AND/OR/XOR/NOR: bitwise on opa and opb; uov = sov = cout = 0.
REQ-018 SLL: res = opb << opa[4:0]; SRL: logical right shift; SRA: arithmetic right shift (replicate opb[31]); opa[31:5] ignored; uov = sov = cout = 0.
REQ-019 JR: res = opa; uov = sov = cout = 0.
REQ-020 Any other func: res = 0, uov = sov = cout = 0.
REQ-021 zero = (res == 0) for every func, including logic, shift, SLT, JR and unsupported codes.
REQ-022 Outputs hold their last value only while inputs are unchanged; no enable, so every edge reloads.

Reset
REQ-023 When rst = 1 at a rising edge: res = 0, uov = 0, sov = 0, cout = 0, zero = 1; operand inputs ignored that cycle.
REQ-024 Reset has priority over any operation in flight; the first valid result appears one cycle after rst deasserts.

Configuration
REQ-025 Macro EE357_ALU_SHIFT_EN: when defined, SLL/SRL/SRA behave per REQ-018; when undefined, the shifter is omitted and those codes follow REQ-020 (res = 0, zero = 1).

Verification
REQ-026 ADD opa=FFFFFFFF, opb=00000001 -> next cycle res=00000000, {uov,sov,zero,cout}=1011; opa=7FFFFFFF, opb=1 -> 80000000, 0100.
REQ-027 SUB 80000000-00000001 -> 7FFFFFFF, flags 0101; 00000000-00000001 -> FFFFFFFF, 1000; FFFFFFFF-FFFFFFFE -> 00000001, 0001.
REQ-028 Logic opa=FFFFFFFF/00000000, opb=0033CCFF: AND -> 0033CCFF; OR (opa=0) -> 0033CCFF; XOR -> FFCC3300; NOR (opa=0) -> FFCC3300; all flags 0000.
REQ-029 Shifts (macro defined): SLL a=1, b=1 -> 00000002; SLL a=1C, b=A -> A0000000; SRL a=1, b=80000000 -> 40000000; SRL a=1F -> 00000001; SRA a=1 -> C0000000; SRA a=1F -> FFFFFFFF; flags 0000.
REQ-030 SLT 0 vs 1 -> 00000001, flags 1000; FFFFFFFF vs FFFFFFFE -> 00000000, flags 0011.
REQ-031 Assert rst mid-stream with ADD FFFFFFFF+1 applied -> next cycle res=0, flags 0010; deassert -> result follows one cycle later.
